// File: rtl/debug_uart_dump.sv
// Debug dump engine: walks the core debug port from address 0 to LAST_ADDR and sends
// one "AA:DDDDDDDD\r\n" ASCII line per address over a UART 8N1 transmitter.
module debug_uart_dump #(
  parameter int unsigned BAUD_DIV  = 868,
  parameter logic [6:0]  LAST_ADDR = 7'd63
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_debug_data,
  output logic [6:0]  o_debug_addr,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done
);

  // Baud counter counts down from BAUD_DIV-1 to 0, so each bit lasts BAUD_DIV cycles.
  localparam logic [15:0] BaudLast = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  LastIdx  = 4'd12;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StCapture,
    StLoad,
    StSend,
    StFinish
  } main_state_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

  // Main sequencer state
  main_state_e r_state, w_state_next;
  logic [6:0]  r_addr, w_addr_next;
  logic [31:0] r_data, w_data_next;
  logic [3:0]  r_idx, w_idx_next;
  logic        w_load;

  // Transmitter state
  tx_state_e   r_tx_state, w_tx_state_next;
  logic [15:0] r_baud_cnt, w_baud_cnt_next;
  logic [3:0]  r_bit_cnt, w_bit_cnt_next;
  logic [7:0]  r_shift, w_shift_next;
  logic        r_tx, w_tx_next;
  logic        w_tx_ready;

  // Character selection
  logic [31:0] w_shifted;
  logic [3:0]  w_nib;
  logic [7:0]  w_char;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Pick the ASCII character for the current line index from the held address/data.
  always_comb begin
    w_shifted = r_data >> {(4'd10 - r_idx), 2'b00};
    w_nib     = w_shifted[3:0];
    w_char    = 8'h3A;
    case (r_idx)
      4'd0:    w_char = hex_char({1'b0, r_addr[6:4]});
      4'd1:    w_char = hex_char(r_addr[3:0]);
      4'd2:    w_char = 8'h3A;
      4'd11:   w_char = 8'h0D;
      4'd12:   w_char = 8'h0A;
      default: w_char = hex_char(w_nib);
    endcase
  end

  // Main sequencer state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_addr  <= 7'd0;
      r_data  <= 32'd0;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_data  <= w_data_next;
      r_idx   <= w_idx_next;
    end
  end

  // Main sequencer next-state: settle address, capture data, then send 13 characters.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_data_next  = r_data;
    w_idx_next   = r_idx;
    w_load       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = StSetup;
          w_addr_next  = 7'd0;
        end
      end
      StSetup: begin
        w_state_next = StCapture;
      end
      StCapture: begin
        // Data is frozen here so core activity mid-line cannot corrupt the line.
        w_data_next  = i_debug_data;
        w_idx_next   = 4'd0;
        w_state_next = StLoad;
      end
      StLoad: begin
        w_load       = 1'b1;
        w_state_next = StSend;
      end
      StSend: begin
        if (w_tx_ready) begin
          if (r_idx < LastIdx) begin
            w_idx_next   = r_idx + 4'd1;
            w_state_next = StLoad;
          end else if (r_addr < LAST_ADDR) begin
            w_addr_next  = r_addr + 7'd1;
            w_state_next = StSetup;
          end else begin
            w_state_next = StFinish;
          end
        end
      end
      StFinish: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Transmitter state register; reset forces the line high immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_state <= TxIdle;
      r_baud_cnt <= 16'd0;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'd0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
    end
  end

  // Transmitter next-state: start bit, 8 data bits LSB first, stop bit.
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_baud_cnt_next = r_baud_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_tx_next       = r_tx;
    unique case (r_tx_state)
      TxIdle: begin
        w_tx_next = 1'b1;
        if (w_load) begin
          w_tx_state_next = TxStart;
          w_baud_cnt_next = BaudLast;
          w_bit_cnt_next  = 4'd0;
          w_shift_next    = w_char;
          w_tx_next       = 1'b0;
        end
      end
      TxStart: begin
        if (r_baud_cnt == 16'd0) begin
          w_tx_state_next = TxData;
          w_baud_cnt_next = BaudLast;
          w_bit_cnt_next  = 4'd0;
          w_tx_next       = r_shift[0];
        end else begin
          w_baud_cnt_next = r_baud_cnt - 16'd1;
        end
      end
      TxData: begin
        if (r_baud_cnt == 16'd0) begin
          w_baud_cnt_next = BaudLast;
          if (r_bit_cnt == 4'd7) begin
            w_tx_state_next = TxStop;
            w_tx_next       = 1'b1;
          end else begin
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_tx_next      = r_shift[1];
            w_bit_cnt_next = r_bit_cnt + 4'd1;
          end
        end else begin
          w_baud_cnt_next = r_baud_cnt - 16'd1;
        end
      end
      TxStop: begin
        if (r_baud_cnt == 16'd0) begin
          w_tx_state_next = TxIdle;
        end else begin
          w_baud_cnt_next = r_baud_cnt - 16'd1;
        end
      end
      default: begin
        w_tx_state_next = TxIdle;
        w_tx_next       = 1'b1;
      end
    endcase
  end

  assign w_tx_ready   = (r_tx_state == TxIdle);
  assign o_tx         = r_tx;
  assign o_debug_addr = r_addr;
  assign o_busy       = (r_state != StIdle);
  assign o_done       = (r_state == StFinish);

endmodule

// File: tb/tb_debug_uart_dump.sv
// Directed bench for debug_uart_dump: three instances with different BAUD_DIV/LAST_ADDR.
module tb_debug_uart_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b0, rst_bc = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [31:0] dbg_a, dbg_b, dbg_c;
  logic [6:0]  addr_a, addr_b, addr_c;
  logic        tx_a, tx_b, tx_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = 32'h0;

  // Core model for dut_a: data = address, unless overridden.
  assign dbg_a = ovr_en ? ovr_val : {25'h0, addr_a};
  assign dbg_b = 32'h1234ABCD;
  assign dbg_c = 32'h0000_0000;

  debug_uart_dump #(.BAUD_DIV(4), .LAST_ADDR(7'd63)) dut_a (
    .i_clk(clk), .i_rst_n(rst_a), .i_start(start_a), .i_debug_data(dbg_a),
    .o_debug_addr(addr_a), .o_tx(tx_a), .o_busy(busy_a), .o_done(done_a)
  );
  debug_uart_dump #(.BAUD_DIV(4), .LAST_ADDR(7'd0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_bc), .i_start(start_b), .i_debug_data(dbg_b),
    .o_debug_addr(addr_b), .o_tx(tx_b), .o_busy(busy_b), .o_done(done_b)
  );
  debug_uart_dump #(.BAUD_DIV(2), .LAST_ADDR(7'd0)) dut_c (
    .i_clk(clk), .i_rst_n(rst_bc), .i_start(start_c), .i_debug_data(dbg_c),
    .o_debug_addr(addr_c), .o_tx(tx_c), .o_busy(busy_c), .o_done(done_c)
  );

  int checks = 0;
  int failures = 0;

  logic qa[$], qb[$], qc[$];
  logic rec_a = 1'b0, rec_b = 1'b0, rec_c = 1'b0;
  int   done_cnt_a = 0, done_cnt_b = 0;

  always @(negedge clk) begin
    if (rec_a) qa.push_back(tx_a);
    if (rec_b) qb.push_back(tx_b);
    if (rec_c) qc.push_back(tx_c);
  end

  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
    if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
  end

  // Strict 8N1 decoder over per-cycle tx samples; every bit must be exactly baud samples.
  function automatic void decode(input logic s[$], input int baud, output logic [7:0] chars[$],
                                 output int bad, output int max_gap);
    int i;
    int last_end;
    logic [9:0] fr;
    chars = {};
    bad = 0;
    max_gap = 0;
    i = 0;
    last_end = -1;
    fr = '0;
    while (i < s.size()) begin
      if (s[i] !== 1'b0) begin
        if (s[i] !== 1'b1) bad++;
        i++;
      end else if (i + 10 * baud > s.size()) begin
        bad++;
        i = s.size();
      end else begin
        for (int k = 0; k < 10; k++) begin
          fr[k] = s[i + k * baud];
          for (int j = 1; j < baud; j++) if (s[i + k * baud + j] !== fr[k]) bad++;
        end
        if (fr[0] !== 1'b0 || fr[9] !== 1'b1) bad++;
        if (last_end >= 0 && i - last_end > max_gap) max_gap = i - last_end;
        chars.push_back(fr[8:1]);
        last_end = i + 10 * baud;
        i = last_end;
      end
    end
  endfunction

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] exp_char(input logic [7:0] a, input logic [31:0] d,
                                          input int idx);
    case (idx)
      0:  return hexc(a[7:4]);
      1:  return hexc(a[3:0]);
      2:  return 8'h3A;
      11: return 8'h0D;
      12: return 8'h0A;
      default: return hexc(d[(10 - idx) * 4 +: 4]);
    endcase
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (tx_a !== 1'b1) begin failures++; $display("FAIL rst_tx: got %b want 1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", done_a); end
    checks++; if (addr_a !== 7'd0) begin failures++; $display("FAIL rst_addr: got %0h want 0", addr_a); end
    rst_a = 1'b1;
    rst_bc = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (tx_a !== 1'b1 || tx_b !== 1'b1 || tx_c !== 1'b1 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL post_rst_idle: got tx=%b%b%b busy=%b want 111/0", tx_a, tx_b, tx_c, busy_a);
    end
  endtask

  task automatic test_single_line();
    logic [7:0] ch[$];
    int bad, gap, lat, n;
    string exp_s;
    exp_s = "00:1234ABCD";
    qb = {};
    rec_b = 1'b1;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    checks++; if (busy_b !== 1'b1) begin failures++; $display("FAIL b_busy: got %b want 1", busy_b); end
    lat = 1;
    while (tx_b !== 1'b0 && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat != 4) begin failures++; $display("FAIL b_latency: got %0d want 4", lat); end
    n = 0;
    while (done_b !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (done_b !== 1'b1) begin failures++; $display("FAIL b_done_timeout: got %b want 1", done_b); end
    @(negedge clk);
    checks++;
    if (done_b !== 1'b0 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL b_done_pulse: got done=%b busy=%b want 0/0", done_b, busy_b);
    end
    repeat (10) @(negedge clk);
    rec_b = 1'b0;
    decode(qb, 4, ch, bad, gap);
    checks++; if (bad != 0) begin failures++; $display("FAIL b_bits: got %0d bad bits want 0", bad); end
    checks++; if (ch.size() != 13) begin failures++; $display("FAIL b_len: got %0d want 13", ch.size()); end
    checks++; if (gap > 2) begin failures++; $display("FAIL b_gap: got %0d want <=2", gap); end
    checks++; if (done_cnt_b != 1) begin failures++; $display("FAIL b_done_cnt: got %0d want 1", done_cnt_b); end
    if (ch.size() >= 13) begin
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (ch[i] !== exp_s[i]) begin
          failures++;
          $display("FAIL b_char%0d: got %02h want %02h", i, ch[i], exp_s[i]);
        end
      end
      checks++;
      if (ch[11] !== 8'h0D || ch[12] !== 8'h0A) begin
        failures++;
        $display("FAIL b_crlf: got %02h %02h want 0d 0a", ch[11], ch[12]);
      end
    end
  endtask

  task automatic test_lf_waveform();
    logic [9:0] pat;
    int n, lz, fs, errs;
    pat = 10'b1000010100;
    qc = {};
    rec_c = 1'b1;
    repeat (3) @(negedge clk);
    start_c = 1'b1;
    @(negedge clk); start_c = 1'b0;
    n = 0;
    while (done_c !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (done_c !== 1'b1) begin failures++; $display("FAIL c_done_timeout: got %b want 1", done_c); end
    repeat (8) @(negedge clk);
    rec_c = 1'b0;
    lz = -1;
    for (int i = 0; i < qc.size(); i++) if (qc[i] === 1'b0) lz = i;
    fs = lz - 17;
    checks++;
    if (fs < 1) begin
      failures++;
      $display("FAIL c_lf_found: got start index %0d want >=1", fs);
    end else begin
      errs = 0;
      for (int j = 0; j < 20; j++) if (qc[fs + j] !== pat[j / 2]) errs++;
      checks++; if (errs != 0) begin failures++; $display("FAIL c_lf_wave: got %0d wrong samples want 0", errs); end
      checks++; if (qc[fs - 1] !== 1'b1) begin failures++; $display("FAIL c_idle_before: got %b want 1", qc[fs - 1]); end
      errs = 0;
      for (int j = fs + 20; j < qc.size(); j++) if (qc[j] !== 1'b1) errs++;
      checks++; if (errs != 0) begin failures++; $display("FAIL c_idle_after: got %0d low samples want 0", errs); end
    end
    checks++; if (qc[0] !== 1'b1) begin failures++; $display("FAIL c_idle_start: got %b want 1", qc[0]); end
  endtask

  task automatic test_full_dump();
    logic [7:0] ch[$];
    int bad, gap, n, line_errs;
    string l2a;
    l2a = "2A:0000002A";
    ovr_en = 1'b0;
    qa = {};
    rec_a = 1'b1;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (100) @(negedge clk);
    // A second request mid-dump must be ignored.
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    n = 0;
    while (done_a !== 1'b1 && n < 40000) begin @(negedge clk); n++; end
    checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL a_done_timeout: got %b want 1", done_a); end
    // Request in the same cycle as done must also be ignored.
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL a_start_on_done: got busy=%b want 0", busy_a); end
    repeat (50) @(negedge clk);
    rec_a = 1'b0;
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL a_busy_end: got %b want 0", busy_a); end
    checks++; if (done_cnt_a != 1) begin failures++; $display("FAIL a_done_cnt: got %0d want 1", done_cnt_a); end
    checks++; if (addr_a !== 7'd63) begin failures++; $display("FAIL a_addr_end: got %0d want 63", addr_a); end
    decode(qa, 4, ch, bad, gap);
    checks++; if (bad != 0) begin failures++; $display("FAIL a_bits: got %0d bad bits want 0", bad); end
    checks++; if (ch.size() != 832) begin failures++; $display("FAIL a_len: got %0d want 832", ch.size()); end
    checks++; if (gap > 4) begin failures++; $display("FAIL a_gap: got %0d want <=4", gap); end
    if (ch.size() == 832) begin
      line_errs = 0;
      for (int a = 0; a < 64; a++)
        for (int k = 0; k < 13; k++)
          if (ch[a * 13 + k] !== exp_char(8'(a), 32'(a), k)) line_errs++;
      checks++; if (line_errs != 0) begin failures++; $display("FAIL a_all_lines: got %0d wrong chars want 0", line_errs); end
      line_errs = 0;
      for (int k = 0; k < 11; k++) if (ch[42 * 13 + k] !== l2a[k]) line_errs++;
      if (ch[42 * 13 + 11] !== 8'h0D || ch[42 * 13 + 12] !== 8'h0A) line_errs++;
      checks++; if (line_errs != 0) begin failures++; $display("FAIL a_line_2a: got %0d wrong chars want 0", line_errs); end
    end
  endtask

  task automatic test_capture_hold();
    logic [7:0] ch[$];
    int bad, gap, n, errs;
    string l0, l1;
    l0 = "00:FFFFFFFF";
    l1 = "01:00000000";
    ovr_en = 1'b1;
    ovr_val = 32'hFFFF_FFFF;
    qa = {};
    rec_a = 1'b1;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    // Lands inside character 5 of line 0.
    repeat (224) @(negedge clk);
    ovr_val = 32'h0;
    n = 0;
    while (addr_a !== 7'd2 && n < 3000) begin @(negedge clk); n++; end
    checks++; if (addr_a !== 7'd2) begin failures++; $display("FAIL h_addr_timeout: got %0d want 2", addr_a); end
    @(negedge clk);
    rec_a = 1'b0;
    decode(qa, 4, ch, bad, gap);
    checks++;
    if (ch.size() < 26) begin
      failures++;
      $display("FAIL h_len: got %0d want >=26", ch.size());
    end else begin
      errs = 0;
      for (int k = 0; k < 11; k++) if (ch[k] !== l0[k]) errs++;
      checks++; if (errs != 0) begin failures++; $display("FAIL h_line0_held: got %0d wrong chars want 0", errs); end
      errs = 0;
      for (int k = 0; k < 11; k++) if (ch[13 + k] !== l1[k]) errs++;
      checks++; if (errs != 0) begin failures++; $display("FAIL h_line1_fresh: got %0d wrong chars want 0", errs); end
    end
  endtask

  task automatic test_reset_mid_send();
    int n, lows;
    n = 0;
    while (!(tx_a === 1'b0 && busy_a === 1'b1) && n < 500) begin @(negedge clk); n++; end
    checks++; if (tx_a !== 1'b0) begin failures++; $display("FAIL r_mid_send: got tx=%b want 0", tx_a); end
    rst_a = 1'b0;
    #1;
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || addr_a !== 7'd0 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL r_async: got tx=%b busy=%b addr=%0d done=%b want 1/0/0/0",
               tx_a, busy_a, addr_a, done_a);
    end
    @(negedge clk);
    rst_a = 1'b1;
    ovr_en = 1'b0;
    qa = {};
    rec_a = 1'b1;
    repeat (200) @(negedge clk);
    rec_a = 1'b0;
    lows = 0;
    for (int i = 0; i < qa.size(); i++) if (qa[i] !== 1'b1) lows++;
    checks++; if (lows != 0) begin failures++; $display("FAIL r_quiet: got %0d low samples want 0", lows); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL r_busy_after: got %b want 0", busy_a); end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_lf_waveform();
    test_full_dump();
    test_capture_hold();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
